uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver.
// Frame: start(0), 8 data bits LSB first, optional parity bit, stop(1).
// The start bit is confirmed at its midpoint. Every later bit is sampled
// OVERSAMPLE ticks after that point, which is also the middle of the bit.
module uart_rx_core #(
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       sample_tick,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_HALF = 4'(OVERSAMPLE / 2 - 1);
    localparam logic       ODD_BIT   = (PARITY_ODD != 0);

    logic [1:0] sync_q;
    logic       rxs;

    state_t     state, state_n;
    logic [3:0] tcnt, tcnt_n;
    logic [2:0] bcnt, bcnt_n;
    logic [7:0] shreg, shreg_n;
    logic       pbit, pbit_n;
    logic       armed, armed_n;
    logic [7:0] rx_data_n;
    logic       rx_valid_n, parity_err_n, frame_err_n;

    assign rxs  = sync_q[1];
    assign busy = (state != IDLE);

    // Two-flop synchronizer for the asynchronous serial line (idles high)
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_in};
        end
    end

    // State, counters, shift register and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            tcnt       <= 4'd0;
            bcnt       <= 3'd0;
            shreg      <= 8'd0;
            pbit       <= 1'b0;
            armed      <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            tcnt       <= tcnt_n;
            bcnt       <= bcnt_n;
            shreg      <= shreg_n;
            pbit       <= pbit_n;
            armed      <= armed_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
            parity_err <= parity_err_n;
            frame_err  <= frame_err_n;
        end
    end

    // Next-state logic; counters only move on sample_tick so tick gaps stall the frame
    always_comb begin
        state_n      = state;
        tcnt_n       = tcnt;
        bcnt_n       = bcnt;
        shreg_n      = shreg;
        pbit_n       = pbit;
        armed_n      = armed | rxs;
        rx_data_n    = rx_data;
        rx_valid_n   = 1'b0;
        parity_err_n = parity_err;
        frame_err_n  = frame_err;

        case (state)
            IDLE: begin
                // armed blocks a line still held low after a break from retriggering
                if (!rxs && armed) begin
                    state_n = START;
                    tcnt_n  = 4'd0;
                end
            end
            START: begin
                if (sample_tick) begin
                    if (tcnt == TICK_HALF) begin
                        tcnt_n = 4'd0;
                        if (!rxs) begin
                            state_n = DATA;
                            bcnt_n  = 3'd0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        tcnt_n = tcnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (sample_tick) begin
                    if (tcnt == TICK_LAST) begin
                        tcnt_n  = 4'd0;
                        shreg_n = {rxs, shreg[7:1]};
                        if (bcnt == 3'd7) begin
                            bcnt_n  = 3'd0;
                            state_n = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bcnt_n = bcnt + 3'd1;
                        end
                    end else begin
                        tcnt_n = tcnt + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (sample_tick) begin
                    if (tcnt == TICK_LAST) begin
                        tcnt_n  = 4'd0;
                        pbit_n  = rxs;
                        state_n = STOP;
                    end else begin
                        tcnt_n = tcnt + 4'd1;
                    end
                end
            end
            STOP: begin
                if (sample_tick) begin
                    if (tcnt == TICK_LAST) begin
                        tcnt_n       = 4'd0;
                        rx_data_n    = shreg;
                        frame_err_n  = ~rxs;
                        parity_err_n = (PARITY_EN != 0) ? (^shreg ^ pbit ^ ODD_BIT) : 1'b0;
                        rx_valid_n   = 1'b1;
                        state_n      = IDLE;
                        if (!rxs) begin
                            armed_n = 1'b0;
                        end
                    end else begin
                        tcnt_n = tcnt + 4'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tcnt_n  = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames into uart_rx_core.
// The stimulus pushes the expected result of every complete frame into a queue.
// A monitor pops one entry and compares it on each rx_valid pulse.
module tb_uart_rx_core;

    localparam int OS = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx_in;
    logic       sample_tick;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   busy_ticks = 0;
    logic prev_v = 1'b0;
    logic stall = 1'b0;

    uart_rx_core #(.OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_in      (rx_in),
        .sample_tick(sample_tick),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Tick generator: every clock normally, random gaps while stall is set
    initial begin
        sample_tick = 1'b0;
        forever begin
            @(negedge clock);
            sample_tick = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Count ticks spent busy (glitch test)
    always @(posedge clock) begin
        if (busy && sample_tick) busy_ticks++;
    end

    // Scoreboard monitor
    always @(negedge clock) begin
        if (rx_valid) begin
            exp_t e;
            pulses++;
            check("rx_valid_one_clock", {7'd0, prev_v}, 8'd0);
            if (q.size() == 0) begin
                check("unexpected_rx_valid", 8'd1, 8'd0);
            end else begin
                e = q.pop_front();
                check("rx_data", rx_data, e.d);
                check("parity_err", {7'd0, parity_err}, {7'd0, e.pe});
                check("frame_err", {7'd0, frame_err}, {7'd0, e.fe});
            end
        end
        prev_v = rx_valid;
    end

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            @(posedge clock);
            if (sample_tick) c++;
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        @(negedge clock);
        rx_in = b;
        wait_ticks(n);
    endtask

    // Sends one frame; abort_bit in 0..7 pulses reset halfway through that data bit
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stp,
                              input int abort_bit, input exp_t e);
        if (abort_bit < 0) q.push_back(e);
        send_bit(1'b0, OS);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_bit) begin
                send_bit(d[i], OS / 2);
                @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                rx_in = 1'b1;
                check("abort_busy", {7'd0, busy}, 8'd0);
                check("abort_rx_valid", {7'd0, rx_valid}, 8'd0);
                return;
            end
            send_bit(d[i], OS);
        end
        send_bit(p, OS);
        send_bit(stp, OS);
    endtask

    initial begin
        reset = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", {7'd0, rx_valid}, 8'd0);
        check("reset_parity_err", {7'd0, parity_err}, 8'd0);
        check("reset_frame_err", {7'd0, frame_err}, 8'd0);
        check("reset_busy", {7'd0, busy}, 8'd0);
        reset = 1'b0;
        send_bit(1'b1, 2 * OS);

        // 0xA5, even parity bit 0, good stop
        send_frame(8'hA5, 1'b0, 1'b1, -1, '{d: 8'hA5, pe: 1'b0, fe: 1'b0});
        send_bit(1'b1, 2 * OS);

        // 4-tick low glitch on an idle line
        busy_ticks = 0;
        send_bit(1'b0, 4);
        send_bit(1'b1, 3 * OS);
        check("glitch_went_busy", {7'd0, (busy_ticks > 0)}, 8'd1);
        check("glitch_busy_le8", {7'd0, (busy_ticks <= 8)}, 8'd1);
        check("glitch_idle_after", {7'd0, busy}, 8'd0);

        // 0x3C with wrong parity bit 1
        send_frame(8'h3C, 1'b1, 1'b1, -1, '{d: 8'h3C, pe: 1'b1, fe: 1'b0});
        send_bit(1'b1, 2 * OS);

        // 0x81 with stop bit 0, then break held for 3 bit times
        send_frame(8'h81, 1'b0, 1'b0, -1, '{d: 8'h81, pe: 1'b0, fe: 1'b1});
        send_bit(1'b0, 3 * OS);
        check("break_no_retrigger", {7'd0, busy}, 8'd0);
        send_bit(1'b1, 2 * OS);

        // Back-to-back frames with stalled ticks
        stall = 1'b1;
        send_frame(8'h00, 1'b0, 1'b1, -1, '{d: 8'h00, pe: 1'b0, fe: 1'b0});
        send_frame(8'hFF, 1'b0, 1'b1, -1, '{d: 8'hFF, pe: 1'b0, fe: 1'b0});
        send_frame(8'h55, 1'b0, 1'b1, -1, '{d: 8'h55, pe: 1'b0, fe: 1'b0});
        send_bit(1'b1, 2 * OS);
        stall = 1'b0;

        // Reset during data bit 4 of 0x12, then 0x34 (odd popcount -> parity bit 1)
        send_frame(8'h12, 1'b0, 1'b1, 4, '{d: 8'h12, pe: 1'b0, fe: 1'b0});
        send_bit(1'b1, 2 * OS);
        send_frame(8'h34, 1'b1, 1'b1, -1, '{d: 8'h34, pe: 1'b0, fe: 1'b0});
        send_bit(1'b1, 2 * OS);

        for (int i = 0; i < 1000 && q.size() != 0; i++) @(negedge clock);
        check("queue_drained", 8'(q.size()), 8'd0);
        check("pulse_count", 8'(pulses), 8'd7);
        check("final_rx_data_held", rx_data, 8'h34);
        check("final_busy", {7'd0, busy}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
